// File: rtl/xtal_osc_32k_ctrl_if.sv
// Interface: xtal_osc_32k_ctrl_if
// Groups the oscillator pins and the host-side control/status signals of the
// 32 kHz crystal controller.
//   master : environment side (host control plus the oscillator's dout pin)
//   slave  : the controller
interface xtal_osc_32k_ctrl_if #(
    parameter int unsigned PER_W = 16
);
    logic             en;
    logic             lost_clr;
    logic             xtal_dout;
    logic             xtal_ena;
    logic             xtal_boost;
    logic             ready;
    logic             clk32_rise;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             lost;
    logic             freq_err;

    modport master (
        output en,
        output lost_clr,
        output xtal_dout,
        input  xtal_ena,
        input  xtal_boost,
        input  ready,
        input  clk32_rise,
        input  period,
        input  period_valid,
        input  lost,
        input  freq_err
    );

    modport slave (
        input  en,
        input  lost_clr,
        input  xtal_dout,
        output xtal_ena,
        output xtal_boost,
        output ready,
        output clk32_rise,
        output period,
        output period_valid,
        output lost,
        output freq_err
    );
endinterface

// File: rtl/xtal_osc_32k_ctrl.sv
// Module: xtal_osc_32k_ctrl
// System-clock-domain controller for the 32 kHz crystal oscillator macro.
// Starts the oscillator with boost, declares it ready after STARTUP_EDGES
// clean rising edges, watches for clock loss and restarts, and measures the
// 32k period in system cycles.
//
// Optional feature: define XTAL_OSC_32K_FREQ_CHECK_EN to enable the period
// window check (PER_MIN/PER_MAX) driving the sticky freq_err flag. Without it
// freq_err is tied low and PER_MIN/PER_MAX do not exist.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_OFF   | oscillator disabled, waiting for en
// ST_START | ena+boost, counting synced rising edges toward STARTUP_EDGES
// ST_RUN   | ena only, ready=1, watching for loss, measuring period
// ST_FAIL  | ena low for RESTART_CYCLES, then retry START
module xtal_osc_32k_ctrl #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STARTUP_EDGES  = 1024,
    parameter int unsigned TMO_W          = 24,
    parameter int unsigned START_TMO      = (1 << 24) - 1,
    parameter int unsigned LOSS_CYCLES    = 1024,
    parameter int unsigned RESTART_CYCLES = 256,
    parameter int unsigned PER_W          = 16
`ifdef XTAL_OSC_32K_FREQ_CHECK_EN
    ,
    parameter int unsigned PER_MIN        = 280,
    parameter int unsigned PER_MAX        = 330
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    xtal_osc_32k_ctrl_if.slave bus
);

    localparam int unsigned EDGE_W = $clog2(STARTUP_EDGES + 1);
    localparam int unsigned RST_W  = $clog2(RESTART_CYCLES + 1);

    localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(STARTUP_EDGES - 1);
    localparam logic [RST_W-1:0]  RST_LOAD    = RST_W'(RESTART_CYCLES - 1);
    localparam logic [TMO_W-1:0]  START_TMO_C = TMO_W'(START_TMO);
    localparam logic [TMO_W-1:0]  LOSS_C      = TMO_W'(LOSS_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic [TMO_W-1:0]       gap_q, gap_d;
    logic [EDGE_W-1:0]      edge_q, edge_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [PER_W-1:0]       per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]       period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   armed_q, armed_d;
    logic                   lost_q, lost_d;
    logic                   ena_q, ena_d;
    logic                   boost_q, boost_d;
    logic                   ready_q, ready_d;
    logic                   freq_err_q, freq_err_d;

    logic                   rise_c;
    logic                   entering;
    logic                   load;
    logic [PER_W-1:0]       per_meas;

    // Next-state and next-output computation for every register in the block.
    always_comb begin
        // Synchronizer chain plus one previous-sample flop for edge detection.
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.xtal_dout};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
        rise_d = rise_c;

        state_d   = state_q;
        edge_d    = edge_q;
        rst_cnt_d = rst_cnt_q;

        unique case (state_q)
            ST_OFF: begin
                if (bus.en) state_d = ST_START;
            end
            ST_START: begin
                // A rise in the same cycle as the timeout wins.
                if (rise_c) begin
                    if (edge_q == EDGE_LAST) state_d = ST_RUN;
                    else                     edge_d  = edge_q + 1'b1;
                end else if (gap_q == START_TMO_C) begin
                    state_d = ST_FAIL;
                end
            end
            ST_RUN: begin
                if (!rise_c && gap_q == LOSS_C) state_d = ST_FAIL;
            end
            ST_FAIL: begin
                if (rst_cnt_q == '0) state_d   = ST_START;
                else                 rst_cnt_d = rst_cnt_q - 1'b1;
            end
            default: state_d = ST_OFF;
        endcase

        if (!bus.en) state_d = ST_OFF;

        entering = (state_d != state_q);
        if (entering) begin
            edge_d = '0;
            if (state_d == ST_FAIL) rst_cnt_d = RST_LOAD;
        end

        // Gap counter: time since the last synced rise within the current state.
        if (entering || rise_c || !bus.en) gap_d = '0;
        else if (gap_q != '1)              gap_d = gap_q + 1'b1;
        else                               gap_d = gap_q;

        // Free-running period counter, re-armed by every rise.
        if (rise_c)               per_cnt_d = '0;
        else if (per_cnt_q != '1) per_cnt_d = per_cnt_q + 1'b1;
        else                      per_cnt_d = per_cnt_q;

        // Counter holds cycles-1 at the rise, so the measurement is count+1.
        per_meas = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;

        // The first rise after entering RUN only arms; later rises load.
        load = rise_c && armed_q && (state_q == ST_RUN) && (state_d == ST_RUN);

        if (state_q != ST_RUN || state_d != ST_RUN) armed_d = 1'b0;
        else if (rise_c)                            armed_d = 1'b1;
        else                                        armed_d = armed_q;

        period_d = load ? per_meas : period_q;

        if (state_d != ST_RUN) period_valid_d = 1'b0;
        else if (load)         period_valid_d = 1'b1;
        else                   period_valid_d = period_valid_q;

        // A FAIL entry outranks a simultaneous clear.
        if (entering && state_d == ST_FAIL) lost_d = 1'b1;
        else if (bus.lost_clr)              lost_d = 1'b0;
        else                                lost_d = lost_q;

`ifdef XTAL_OSC_32K_FREQ_CHECK_EN
        if (!bus.en)
            freq_err_d = 1'b0;
        else if (load && (per_meas < PER_W'(PER_MIN) || per_meas > PER_W'(PER_MAX)))
            freq_err_d = 1'b1;
        else if (bus.lost_clr)
            freq_err_d = 1'b0;
        else
            freq_err_d = freq_err_q;
`else
        freq_err_d = 1'b0;
`endif

        // Outputs decoded from the next state so they line up with state_q.
        ena_d   = (state_d == ST_START) || (state_d == ST_RUN);
        boost_d = (state_d == ST_START);
        ready_d = (state_d == ST_RUN);
    end

    // All state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OFF;
            sync_q         <= '0;
            prev_q         <= 1'b0;
            rise_q         <= 1'b0;
            gap_q          <= '0;
            edge_q         <= '0;
            rst_cnt_q      <= '0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            armed_q        <= 1'b0;
            lost_q         <= 1'b0;
            ena_q          <= 1'b0;
            boost_q        <= 1'b0;
            ready_q        <= 1'b0;
            freq_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            rise_q         <= rise_d;
            gap_q          <= gap_d;
            edge_q         <= edge_d;
            rst_cnt_q      <= rst_cnt_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            armed_q        <= armed_d;
            lost_q         <= lost_d;
            ena_q          <= ena_d;
            boost_q        <= boost_d;
            ready_q        <= ready_d;
            freq_err_q     <= freq_err_d;
        end
    end

    assign bus.xtal_ena     = ena_q;
    assign bus.xtal_boost   = boost_q;
    assign bus.ready        = ready_q;
    assign bus.clk32_rise   = rise_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.lost         = lost_q;
    assign bus.freq_err     = freq_err_q;

endmodule

// File: tb/tb_xtal_osc_32k_ctrl.sv
// Testbench: tb_xtal_osc_32k_ctrl
// Directed bench for xtal_osc_32k_ctrl with STARTUP_EDGES=8, LOSS_CYCLES=64,
// START_TMO=2000, RESTART_CYCLES=4. xtal_dout toggles every `half` clocks.
// Build with XTAL_OSC_32K_FREQ_CHECK_EN to exercise the period window check.
`timescale 1ns/1ps
module tb_xtal_osc_32k_ctrl;
    localparam int PER_W = 16;

`ifdef XTAL_OSC_32K_FREQ_CHECK_EN
    localparam logic FE_EXP = 1'b1;
`else
    localparam logic FE_EXP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int half    = 20;
    bit dout_run = 1'b0;

    always #5 clk = ~clk;

    xtal_osc_32k_ctrl_if #(.PER_W(PER_W)) bus ();

    xtal_osc_32k_ctrl #(
        .SYNC_STAGES    (2),
        .STARTUP_EDGES  (8),
        .TMO_W          (24),
        .START_TMO      (2000),
        .LOSS_CYCLES    (64),
        .RESTART_CYCLES (4),
        .PER_W          (PER_W)
`ifdef XTAL_OSC_32K_FREQ_CHECK_EN
        ,
        .PER_MIN        (35),
        .PER_MAX        (45)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance at least one cycle, then until a clk32_rise pulse is seen.
    task automatic wait_rise(input int max_cyc, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.clk32_rise !== 1'b1 && n < max_cyc);
        chk(tag, bus.clk32_rise, 1'b1);
    endtask

    // Count cycles until xtal_ena reaches the given level.
    task automatic wait_ena(input logic lvl, input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.xtal_ena !== lvl && n < max_cyc);
    endtask

    // Oscillator model: toggles dout every `half` clocks while running, else low.
    initial begin
        int cnt = 0;
        bus.xtal_dout = 1'b0;
        forever begin
            @(negedge clk);
            if (!dout_run) begin
                bus.xtal_dout = 1'b0;
                cnt = 0;
            end else if (cnt >= half - 1) begin
                cnt = 0;
                bus.xtal_dout = ~bus.xtal_dout;
            end else begin
                cnt++;
            end
        end
    end

    // Directed sequence.
    initial begin
        int n;
        int m;
        bus.en       = 1'b0;
        bus.lost_clr = 1'b0;
        rst_n        = 1'b0;
        repeat (3) tick();

        chk("rst_ena",          bus.xtal_ena,     1'b0);
        chk("rst_boost",        bus.xtal_boost,   1'b0);
        chk("rst_ready",        bus.ready,        1'b0);
        chk("rst_rise",         bus.clk32_rise,   1'b0);
        chk("rst_period",       bus.period,       16'd0);
        chk("rst_period_valid", bus.period_valid, 1'b0);
        chk("rst_lost",         bus.lost,         1'b0);
        chk("rst_freq_err",     bus.freq_err,     1'b0);

        rst_n = 1'b1;
        tick();

        // 1: normal startup, ready after 8 rises, period 40 on 2nd rise in RUN
        half = 20; dout_run = 1'b1; bus.en = 1'b1;
        tick();
        chk("t1_ena",   bus.xtal_ena,   1'b1);
        chk("t1_boost", bus.xtal_boost, 1'b1);
        chk("t1_ready0", bus.ready,     1'b0);
        for (int i = 0; i < 7; i++) wait_rise(60, "t1_rise");
        chk("t1_ready_7", bus.ready, 1'b0);
        wait_rise(60, "t1_rise8");
        chk("t1_ready_8", bus.ready,      1'b1);
        chk("t1_boost_8", bus.xtal_boost, 1'b0);
        chk("t1_ena_8",   bus.xtal_ena,   1'b1);
        wait_rise(60, "t1_run_rise1");
        chk("t1_pv_first", bus.period_valid, 1'b0);
        wait_rise(60, "t1_run_rise2");
        chk("t1_period",   bus.period,       16'd40);
        chk("t1_pv",       bus.period_valid, 1'b1);
        chk("t1_freq_err", bus.freq_err,     1'b0);
        chk("t1_lost",     bus.lost,         1'b0);

        // 2: clock loss in RUN -> FAIL ~64 cycles later, 4 cycles off, restart
        wait_rise(60, "t2_last_rise");
        dout_run = 1'b0;
        wait_ena(1'b0, 200, n);
        chk_rng("t2_loss_delay", n, 64, 66);
        chk("t2_lost",      bus.lost,         1'b1);
        chk("t2_ready",     bus.ready,        1'b0);
        chk("t2_pv_clr",    bus.period_valid, 1'b0);
        chk("t2_period_kept", bus.period,     16'd40);
        wait_ena(1'b1, 50, m);
        chk("t2_off_cycles", m, 4);
        chk("t2_boost", bus.xtal_boost, 1'b1);
        dout_run = 1'b1;
        for (int i = 0; i < 8; i++) wait_rise(60, "t2_rise");
        chk("t2_ready_again", bus.ready, 1'b1);
        chk("t2_lost_kept",   bus.lost,  1'b1);

        // 5: lost_clr clears; lost_clr at FAIL entry loses to the set
        bus.lost_clr = 1'b1;
        tick();
        bus.lost_clr = 1'b0;
        chk("t5_lost_clr", bus.lost, 1'b0);
        wait_rise(60, "t5_rise");
        dout_run = 1'b0;
        bus.lost_clr = 1'b1;
        tick();
        chk("t5_lost_pre", bus.lost, 1'b0);
        wait_ena(1'b0, 200, n);
        bus.lost_clr = 1'b0;
        chk("t5_lost_set_wins", bus.lost, 1'b1);
        wait_ena(1'b1, 50, m);
        chk("t5_lost_after", bus.lost, 1'b1);

        // 3: dout stuck low -> START timeout at ~2000 cycles, retry every ~2004
        bus.lost_clr = 1'b1;
        bus.en = 1'b0;
        tick();
        bus.lost_clr = 1'b0;
        chk("t3_off_ena",  bus.xtal_ena, 1'b0);
        chk("t3_lost_clr", bus.lost,     1'b0);
        bus.en = 1'b1;
        wait_ena(1'b0, 2100, n);
        chk_rng("t3_start_tmo", n, 2000, 2003);
        chk("t3_lost", bus.lost, 1'b1);
        wait_ena(1'b1, 50, m);
        chk("t3_off_cycles", m, 4);
        wait_ena(1'b0, 2100, n);
        chk_rng("t3_retry_tmo", n, 1999, 2003);
        dout_run = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ready !== 1'b1 && n < 3000);
        chk("t3_recover_ready", bus.ready, 1'b1);

        // 4: en=0 after 5 edges in START -> OFF; re-enable needs 8 fresh edges
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) wait_rise(60, "t4_rise");
        chk("t4_in_start", bus.xtal_boost, 1'b1);
        bus.en = 1'b0;
        tick();
        chk("t4_off_ena",   bus.xtal_ena,   1'b0);
        chk("t4_off_boost", bus.xtal_boost, 1'b0);
        chk("t4_off_ready", bus.ready,      1'b0);
        bus.en = 1'b1;
        for (int i = 0; i < 7; i++) wait_rise(60, "t4_rerise");
        chk("t4_ready_7", bus.ready, 1'b0);
        wait_rise(60, "t4_rerise8");
        chk("t4_ready_8", bus.ready, 1'b1);

        // 6: period 50 against window 35..45 (only flagged with the check built in)
        wait_rise(60, "t6_arm");
        wait_rise(60, "t6_load40");
        chk("t6_pv40", bus.period_valid, 1'b1);
        bus.en = 1'b0;
        tick();
        chk("t6_pv_off",       bus.period_valid, 1'b0);
        chk("t6_period_kept",  bus.period,       16'd40);
        half = 25;
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) wait_rise(80, "t6_rise");
        chk("t6_ready", bus.ready, 1'b1);
        wait_rise(80, "t6_run_rise1");
        chk("t6_fe_before", bus.freq_err, 1'b0);
        wait_rise(80, "t6_run_rise2");
        chk("t6_period50", bus.period,   16'd50);
        chk("t6_freq_err", bus.freq_err, FE_EXP);
        chk("t6_state_kept", bus.ready,  1'b1);
        bus.en = 1'b0;
        tick();
        chk("t6_fe_clr_en", bus.freq_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
